rc4_phase_sched: RTL and testbench

//  Top-level sequencer for the RC4 core. Runs the three phase FSMs in order:

---
 rtl/rc4_pkg.sv | 42 ++++
 rtl/s_mem_mux.sv | 25 ++
 rtl/rc4_phase_sched.sv | 139 +++++++++++++
 tb/tb_rc4_phase_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types for the RC4 phase scheduler: state encoding, S-port payload and port selection.
// The optional key-search feature is controlled by RC4_KEY_SEARCH_EN in rc4_phase_sched.
package rc4_pkg;

  localparam int unsigned S_ADDR_W = 8;
  localparam int unsigned S_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SHUF,
    ST_PRGA,
    ST_CHECK,
    ST_DONE
  } sched_state_t;

  typedef enum logic [1:0] {
    SEL_INIT,
    SEL_SHUF,
    SEL_PRGA
  } s_sel_t;

  typedef struct packed {
    logic [S_ADDR_W-1:0] addr;
    logic [S_DATA_W-1:0] data;
    logic                wr;
  } s_port_t;

  // Which phase FSM owns the S-port in a given state (meaningful only when owns_s_port is true).
  function automatic s_sel_t sel_for(input sched_state_t st);
    case (st)
      ST_SHUF: return SEL_SHUF;
      ST_PRGA: return SEL_PRGA;
      default: return SEL_INIT;
    endcase
  endfunction

  function automatic logic owns_s_port(input sched_state_t st);
    return (st == ST_INIT) || (st == ST_SHUF) || (st == ST_PRGA);
  endfunction

endpackage

// File: rtl/s_mem_mux.sv
// 3:1 S-memory port mux; the forced-idle input blanks the whole port so no write can leak through.
module s_mem_mux
  import rc4_pkg::*;
(
  input  s_sel_t  i_sel,
  input  logic    i_idle,
  input  s_port_t i_init,
  input  s_port_t i_shuf,
  input  s_port_t i_prga,
  output s_port_t o_port
);

  always_comb begin
    o_port = '0;
    if (!i_idle) begin
      case (i_sel)
        SEL_INIT: o_port = i_init;
        SEL_SHUF: o_port = i_shuf;
        SEL_PRGA: o_port = i_prga;
        default:  o_port = '0;
      endcase
    end
  end

endmodule

// File: rtl/rc4_phase_sched.sv
// RC4 top-level sequencer: runs init -> shuffle -> PRGA and grants the single-port S-memory.
// Define RC4_KEY_SEARCH_EN to add the CHECK state that steps the key until prga_ok or KEY_MAX.
module rc4_phase_sched
  import rc4_pkg::*;
#(
  parameter int unsigned       KEY_W   = 24,
  parameter logic [KEY_W-1:0]  KEY_MAX = KEY_W'(24'h3FFFFF)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_W-1:0]    key_in,
  output logic [KEY_W-1:0]    key,
  output logic                init_start,
  input  logic                init_fin,
  input  logic [S_ADDR_W-1:0] init_addr,
  input  logic [S_DATA_W-1:0] init_data,
  input  logic                init_wr,
  output logic                shuf_start,
  input  logic                shuf_fin,
  input  logic [S_ADDR_W-1:0] shuf_addr,
  input  logic [S_DATA_W-1:0] shuf_data,
  input  logic                shuf_wr,
  output logic                prga_start,
  input  logic                prga_fin,
  input  logic [S_ADDR_W-1:0] prga_addr,
  input  logic [S_DATA_W-1:0] prga_data,
  input  logic                prga_wr,
  input  logic                prga_ok,
  output logic [S_ADDR_W-1:0] s_addr,
  output logic [S_DATA_W-1:0] s_data,
  output logic                s_wr,
  output logic                busy,
  output logic                done,
  output logic                fail
);

  sched_state_t     r_state, w_next;
  logic [KEY_W-1:0] r_key, w_key_next;
  logic             r_fail, w_fail_next;
  logic             r_init_start, r_shuf_start, r_prga_start, r_busy, r_done;
  logic             w_init_start, w_shuf_start, w_prga_start, w_busy, w_done;
  s_port_t          w_init_port, w_shuf_port, w_prga_port, w_s_port;

  // Next state, key/fail update and the next values of the registered strobes.
  always_comb begin
    w_next      = r_state;
    w_key_next  = r_key;
    w_fail_next = r_fail;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next      = ST_INIT;
          w_key_next  = key_in;
          w_fail_next = 1'b0;
        end
      end
      ST_INIT: if (init_fin) w_next = ST_SHUF;
      ST_SHUF: if (shuf_fin) w_next = ST_PRGA;
`ifdef RC4_KEY_SEARCH_EN
      ST_PRGA: if (prga_fin) w_next = ST_CHECK;
      ST_CHECK: begin
        if (prga_ok) begin
          w_next = ST_DONE;
        end else if (r_key != KEY_MAX) begin
          w_key_next = r_key + KEY_W'(1);
          w_next     = ST_INIT;
        end else begin
          w_fail_next = 1'b1;
          w_next      = ST_DONE;
        end
      end
`else
      ST_PRGA: if (prga_fin) w_next = ST_DONE;
`endif
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase

    // Phase start strobes fire on entry, including a search-mode rerun from CHECK.
    w_init_start = (w_next == ST_INIT) && (r_state != ST_INIT);
    w_shuf_start = (w_next == ST_SHUF) && (r_state != ST_SHUF);
    w_prga_start = (w_next == ST_PRGA) && (r_state != ST_PRGA);
    w_busy       = (w_next != ST_IDLE);
    w_done       = (w_next == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_key        <= '0;
      r_fail       <= 1'b0;
      r_init_start <= 1'b0;
      r_shuf_start <= 1'b0;
      r_prga_start <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_key        <= w_key_next;
      r_fail       <= w_fail_next;
      r_init_start <= w_init_start;
      r_shuf_start <= w_shuf_start;
      r_prga_start <= w_prga_start;
      r_busy       <= w_busy;
      r_done       <= w_done;
    end
  end

`ifndef RC4_KEY_SEARCH_EN
  logic w_unused_cfg;
  assign w_unused_cfg = prga_ok ^ (KEY_MAX == '0);
`endif

  assign w_init_port = '{addr: init_addr, data: init_data, wr: init_wr};
  assign w_shuf_port = '{addr: shuf_addr, data: shuf_data, wr: shuf_wr};
  assign w_prga_port = '{addr: prga_addr, data: prga_data, wr: prga_wr};

  s_mem_mux u_s_mem_mux (
    .i_sel  (sel_for(r_state)),
    .i_idle (!owns_s_port(r_state)),
    .i_init (w_init_port),
    .i_shuf (w_shuf_port),
    .i_prga (w_prga_port),
    .o_port (w_s_port)
  );

  assign s_addr     = w_s_port.addr;
  assign s_data     = w_s_port.data;
  assign s_wr       = w_s_port.wr;
  assign key        = r_key;
  assign fail       = r_fail;
  assign init_start = r_init_start;
  assign shuf_start = r_shuf_start;
  assign prga_start = r_prga_start;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_rc4_phase_sched.sv
// Scoreboard bench for rc4_phase_sched: the driver plays the three phase FSMs and queues expected strobes.
// Search-mode scenarios are built only when RC4_KEY_SEARCH_EN is defined.
module tb_rc4_phase_sched;

  localparam int EV_INIT = 0;
  localparam int EV_SHUF = 1;
  localparam int EV_PRGA = 2;
  localparam int EV_DONE = 3;
`ifdef RC4_KEY_SEARCH_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  typedef struct {
    int          kind;
    int          cyc;
    logic [23:0] key;
    logic        fail;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [23:0] key_in, key;
  logic        init_start, init_fin, init_wr;
  logic        shuf_start, shuf_fin, shuf_wr;
  logic        prga_start, prga_fin, prga_wr, prga_ok;
  logic [7:0]  init_addr, init_data, shuf_addr, shuf_data, prga_addr, prga_data;
  logic [7:0]  s_addr, s_data;
  logic        s_wr, busy, done, fail;

  int  cyc = 0;
  int  n_pass = 0;
  int  n_total = 0;
  ev_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rc4_phase_sched #(.KEY_W(24), .KEY_MAX(24'h000003)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .key(key),
    .init_start(init_start), .init_fin(init_fin), .init_addr(init_addr),
    .init_data(init_data), .init_wr(init_wr),
    .shuf_start(shuf_start), .shuf_fin(shuf_fin), .shuf_addr(shuf_addr),
    .shuf_data(shuf_data), .shuf_wr(shuf_wr),
    .prga_start(prga_start), .prga_fin(prga_fin), .prga_addr(prga_addr),
    .prga_data(prga_data), .prga_wr(prga_wr), .prga_ok(prga_ok),
    .s_addr(s_addr), .s_data(s_data), .s_wr(s_wr),
    .busy(busy), .done(done), .fail(fail)
  );

  task automatic tally(input bit ok, input string name, input string detail);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ev(input int kind, input int dc, input logic [23:0] k, input logic f);
    ev_t e;
    e.kind = kind; e.cyc = cyc + dc; e.key = k; e.fail = f;
    q.push_back(e);
  endtask

  // Every strobe must match the head of the expectation queue, in kind, cycle, key and fail.
  always @(negedge clk) begin
    logic [3:0] strb;
    ev_t        e;
    strb = {done, prga_start, shuf_start, init_start};
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        if (q.size() == 0) begin
          tally(1'b0, "unexpected_strobe", $sformatf("got kind=%0d at cyc=%0d, want no strobe", i, cyc));
        end else begin
          e = q.pop_front();
          tally((e.kind == i) && (e.cyc == cyc) && (e.key == key) && (e.fail == fail) && busy,
                $sformatf("event_k%0d", e.kind),
                $sformatf("got kind=%0d cyc=%0d key=%h fail=%b busy=%b, want kind=%0d cyc=%0d key=%h fail=%b busy=1",
                          i, cyc, key, fail, busy, e.kind, e.cyc, e.key, e.fail));
        end
      end
    end
  end

  task automatic start_run(input logic [23:0] k);
    push_ev(EV_INIT, 1, k, 1'b0);
    start = 1'b1; key_in = k;
    step(1);
    start = 1'b0;
  endtask

  task automatic ph_init(input int t, input logic [23:0] k, input logic f);
    push_ev(EV_SHUF, t, k, f);
    step(t - 1); init_fin = 1'b1;
    step(1);     init_fin = 1'b0;
  endtask

  task automatic ph_shuf(input int t, input logic [23:0] k, input logic f);
    push_ev(EV_PRGA, t, k, f);
    step(t - 1); shuf_fin = 1'b1;
    step(1);     shuf_fin = 1'b0;
  endtask

  task automatic ph_prga(input int t, input logic ok, input int nkind, input logic [23:0] nk,
                         input logic nf);
    push_ev(nkind, t + CHK, nk, nf);
    step(t - 1); prga_fin = 1'b1; prga_ok = ok;
    step(1);     prga_fin = 1'b0;
    step(CHK);   prga_ok = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 ns, want bench completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; key_in = 24'h0;
    init_fin = 0; shuf_fin = 0; prga_fin = 0; prga_ok = 0;
    init_wr = 1'b1; init_addr = 8'hAA; init_data = 8'hBB;
    shuf_wr = 0; shuf_addr = 0; shuf_data = 0;
    prga_wr = 0; prga_addr = 0; prga_data = 0;

    // Reset state, with a non-owner write pending on the init port.
    step(2);
    #1;
    tally({init_start, shuf_start, prga_start, done} == 4'b0, "rst_strobes",
          $sformatf("got %b, want 0000", {init_start, shuf_start, prga_start, done}));
    tally(busy == 1'b0 && fail == 1'b0, "rst_busy_fail", $sformatf("got busy=%b fail=%b, want 0 0", busy, fail));
    tally(key == 24'h0, "rst_key", $sformatf("got %h, want 000000", key));
    tally(s_wr == 0 && s_addr == 0 && s_data == 0, "rst_sport",
          $sformatf("got wr=%b addr=%h data=%h, want 0 00 00", s_wr, s_addr, s_data));
    rst = 1'b0; init_wr = 1'b0; init_addr = 0; init_data = 0;
    step(1);

    // Nominal run with fins 5, 10 and 7 cycles after each start.
    start_run(24'h000249);
    ph_init(5, 24'h000249, 1'b0);
    ph_shuf(10, 24'h000249, 1'b0);
    ph_prga(7, 1'b1, EV_DONE, 24'h000249, 1'b0);
    step(1);
    #1;
    tally(busy == 1'b0, "idle_after_done", $sformatf("got busy=%b, want 0", busy));
    init_wr = 1'b1; #1;
    tally(s_wr == 1'b0, "idle_no_wr", $sformatf("got s_wr=%b, want 0", s_wr));
    init_wr = 1'b0;

    // Fin on the same cycle as the start strobe; prga_ok=0 in the default build.
    start_run(24'h00F00D);
    ph_init(1, 24'h00F00D, 1'b0);
    ph_shuf(1, 24'h00F00D, 1'b0);
`ifdef RC4_KEY_SEARCH_EN
    ph_prga(1, 1'b1, EV_DONE, 24'h00F00D, 1'b0);
`else
    ph_prga(1, 1'b0, EV_DONE, 24'h00F00D, 1'b0);
`endif
    step(1);
    #1;
    tally(fail == 1'b0 && key == 24'h00F00D, "key_fail_hold",
          $sformatf("got key=%h fail=%b, want 00f00d 0", key, fail));

    // Stray fins, start while busy, and a non-owner write.
    start_run(24'h00ABCD);
    push_ev(EV_SHUF, 6, 24'h00ABCD, 1'b0);
    step(2);
    shuf_fin = 1'b1; start = 1'b1; key_in = 24'hFFFFFF; prga_wr = 1'b1;
    init_wr = 1'b1; init_addr = 8'h11; init_data = 8'h22;
    #1;
    tally(s_wr == 1 && s_addr == 8'h11 && s_data == 8'h22, "init_owner",
          $sformatf("got wr=%b addr=%h data=%h, want 1 11 22", s_wr, s_addr, s_data));
    step(1);
    shuf_fin = 1'b0; start = 1'b0; init_wr = 1'b0; init_addr = 0; init_data = 0;
    step(2); init_fin = 1'b1;
    step(1); init_fin = 1'b0;
    prga_fin = 1'b1; prga_addr = 8'h33; prga_data = 8'h44;
    #1;
    tally(s_wr == 1'b0 && s_addr == 8'h00, "shuf_blocks_prga",
          $sformatf("got wr=%b addr=%h, want 0 00", s_wr, s_addr));
    step(1);
    prga_fin = 1'b0; shuf_wr = 1'b1; shuf_addr = 8'h55; shuf_data = 8'h66;
    #1;
    tally(s_wr == 1 && s_addr == 8'h55 && s_data == 8'h66, "shuf_owner",
          $sformatf("got wr=%b addr=%h data=%h, want 1 55 66", s_wr, s_addr, s_data));
    prga_wr = 1'b0; prga_addr = 0; prga_data = 0;
    ph_shuf(3, 24'h00ABCD, 1'b0);
    shuf_wr = 1'b0; shuf_addr = 0; shuf_data = 0;
    ph_prga(2, 1'b1, EV_DONE, 24'h00ABCD, 1'b0);
    step(1);

    // Reset in SHUF while the owner is writing.
    start_run(24'h000777);
    ph_init(2, 24'h000777, 1'b0);
    shuf_wr = 1'b1; shuf_addr = 8'h09;
    rst = 1'b1;
    step(1);
    #1;
    tally(busy == 0 && s_wr == 0 && done == 0, "rst_midrun",
          $sformatf("got busy=%b s_wr=%b done=%b, want 0 0 0", busy, s_wr, done));
    tally(key == 24'h0, "rst_midrun_key", $sformatf("got %h, want 000000", key));
    rst = 1'b0; shuf_wr = 1'b0; shuf_addr = 0;
    step(3);

`ifdef RC4_KEY_SEARCH_EN
    // Search: keys 0 and 1 rejected, key 2 accepted.
    start_run(24'h0);
    ph_init(3, 24'h0, 1'b0);
    ph_shuf(3, 24'h0, 1'b0);
    ph_prga(2, 1'b0, EV_INIT, 24'h1, 1'b0);
    ph_init(3, 24'h1, 1'b0);
    ph_shuf(3, 24'h1, 1'b0);
    ph_prga(2, 1'b0, EV_INIT, 24'h2, 1'b0);
    ph_init(3, 24'h2, 1'b0);
    ph_shuf(3, 24'h2, 1'b0);
    ph_prga(2, 1'b1, EV_DONE, 24'h2, 1'b0);
    step(1);

    // Search: key space exhausted at KEY_MAX=3, fail sticky until the next start.
    start_run(24'h3);
    ph_init(2, 24'h3, 1'b0);
    ph_shuf(2, 24'h3, 1'b0);
    ph_prga(2, 1'b0, EV_DONE, 24'h3, 1'b1);
    step(2);
    #1;
    tally(fail == 1'b1 && busy == 1'b0, "fail_sticky", $sformatf("got fail=%b busy=%b, want 1 0", fail, busy));
    start_run(24'h3);
    ph_init(2, 24'h3, 1'b0);
    ph_shuf(2, 24'h3, 1'b0);
    ph_prga(2, 1'b1, EV_DONE, 24'h3, 1'b0);
    step(1);
`endif

    step(3);
    tally(q.size() == 0, "queue_drained", $sformatf("got %0d pending events, want 0", q.size()));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
